gen_nonlinear_part: RTL and testbench
=====================================

Name: gen_nonlinear_part

Overview:
- Sequential generator of the non-linear (AND-monomial) terms of the decomposed CLA adder.
- Produces the n vector that the linear part XOR-chains with a^b to form the sum.
- Computes one carry's monomial block per cycle, bit-serially from LSB upward, behind valid/ready handshakes on both sides.
- Sits between the operand source and the linear sum stage.

Parameters:
- NBIT, 7: adder width. Supplied by constants.v.
- NNL, 2**(NBIT+2)-NBIT-4: number of non-linear terms. Derived in constants.v; never overridden on its own.
- TMAX, 2**(NBIT+1)-1: term count of the widest block (carry NBIT). Local, derived.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  operands present
- in_ready  out  1  block can accept operands
- a  in  NBIT  operand A
- b  in  NBIT  operand B
- c_in  in  1  carry in
- out_valid  out  1  n complete and stable
- out_ready  in  1  consumer takes n
- n  out  NNL  non-linear terms
- busy  out  1  state is RUN

Behaviour:
- Term algebra. c_0 = c_in is one term. Carry c_{k+1} has T(k+1) = 2*T(k)+1 terms, with T(k) = 2**(k+1)-1.
- Block ordering for c_{k+1}, at offset O(k+1) = sum over j=1..k of T(j):
  - index 0 = a[k]&b[k]
  - indices 1..T(k) = a[k] & term_j(c_k), j ascending
  - indices T(k)+1..2T(k) = b[k] & term_j(c_k), j ascending
- XOR of block c_{k+1} equals the true ripple carry into bit k+1. Blocks c_1..c_NBIT fill n[NNL-1:0] exactly; c_NBIT is the carry-out block.
- Internal registers:
  - a_q, b_q, c_in_q: latched operands
  - cur[TMAX-1:0]: current block, zero-extended
  - k: counter, 0..NBIT-1
  - state
- FSM states IDLE, RUN, DONE.
  - IDLE: in_ready=1. On in_valid: latch operands; cur <= {0.., c_in}; k <= 0; n <= 0; go to RUN.
  - RUN: each cycle builds block c_{k+1} from cur and a_q[k], b_q[k]; writes it to cur and to n[O(k+1) +: T(k+1)]. If k==NBIT-1 go to DONE, else k <= k+1.
  - DONE: out_valid=1; n held stable. On out_ready go to IDLE; in_ready returns the next cycle. No accept in the same cycle as the DONE->IDLE transition.
- Latency:
  - Operands accepted at edge E; out_valid is high after edge E+NBIT.
  - Throughput: one operation per NBIT+2 cycles when out_ready is held high.
- n bits not yet written during RUN read 0. Consumers sample only when out_valid=1.
- in_valid is ignored outside IDLE; in_ready=0 in RUN and DONE. out_ready is ignored outside DONE.
- Operand changes after acceptance have no effect.
- Reset values (apply immediately, also mid-RUN or mid-DONE): state=IDLE, in_ready=1, out_valid=0, busy=0, n=0, cur=0, k=0, operand registers=0. Any partial result is discarded.
- NBIT=1: a single RUN cycle, k==0 is terminal.

Optional Feature:
- Macro NL_CARRY_CHECK_EN.
- When defined:
  - A parallel ripple carry is computed from a_q, b_q, c_in_q and compared each RUN cycle against the XOR-reduction of the new block.
  - Extra output port chk_err (1 bit) is sticky-set on any mismatch. It is cleared by rst or by acceptance of new operands. It is valid with out_valid.
- When undefined: no chk_err port and no checking logic. Behaviour is otherwise identical.

Test Plan:
- NBIT=2 (NNL=10); a=2'b11, b=2'b01, c_in=1 -> after 2 RUN cycles, out_valid=1 with n=10'h077. Block c1=3'b111, block c2=7'b0001110.
- NBIT=2; a=0, b=0, c_in=0 -> n=10'h000. out_valid rises exactly 2 cycles after the accept edge.
- NBIT=7 (NNL=501); 1000 random a, b, c_in -> for each k, XOR of the block at O(k) equals the reference ripple carry k. Feeding n to gen_linear_part gives s == (a+b+c_in)[6:0] for c_in=0 vectors.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> n stable, in_ready=0, a new in_valid is ignored. Release -> IDLE, then accept on the next cycle.
- Assert rst in the middle of the 4th RUN cycle (NBIT=7) -> outputs return to reset values immediately. The next transaction completes correctly.
- NL_CARRY_CHECK_EN defined; force one cur bit via a bench hook -> chk_err=1 at out_valid. Next clean transaction gives chk_err=0.

Source files
------------

// File: rtl/gen_nonlinear_part.sv
// gen_nonlinear_part: bit-serial generator of the AND-monomial (non-linear) terms
// of the decomposed CLA adder. One carry block c_{k+1} is produced per RUN cycle,
// LSB first, and packed into n. Valid/ready handshakes sit on both sides.
// Optional carry self-check: define NL_CARRY_CHECK_EN to add the chk_err output.
module gen_nonlinear_part #(
    parameter  int unsigned NBIT = 7,
    localparam int unsigned NNL  = (32'd1 << (NBIT + 32'd2)) - NBIT - 32'd4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [NBIT-1:0] a,
    input  logic [NBIT-1:0] b,
    input  logic            c_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [NNL-1:0]  n,
`ifdef NL_CARRY_CHECK_EN
    output logic            chk_err,
`endif
    output logic            busy
);

    // Width of the widest block (carry-out block c_NBIT).
    localparam int unsigned TMAX = (32'd1 << (NBIT + 32'd1)) - 32'd1;
    localparam int unsigned KW   = (NBIT > 1) ? $clog2(NBIT) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q;
    logic [NBIT-1:0]   a_q;
    logic [NBIT-1:0]   b_q;
    logic              c_in_q;
    logic [TMAX-1:0]   cur_q;
    logic [KW-1:0]     k_q;
    logic [NNL-1:0]    n_q;
    logic              in_ready_q;
    logic              out_valid_q;
    logic              busy_q;

    logic [TMAX-1:0]   blk_d;
    logic [NNL-1:0]    n_d;
    int unsigned       k_idx;
    int unsigned       t_cur;
    int unsigned       blk_off;
    logic              a_bit;
    logic              b_bit;

    // Build block c_{k+1} from c_k: {b&c_k terms, a&c_k terms, a&b}, then OR it into n at its offset.
    always_comb begin
        k_idx   = 32'(k_q);
        t_cur   = (32'd1 << (k_idx + 32'd1)) - 32'd1;
        blk_off = (32'd1 << (k_idx + 32'd2)) - 32'd4 - k_idx;
        a_bit   = 1'b0;
        b_bit   = 1'b0;
        for (int unsigned i = 0; i < NBIT; i++) begin
            if (i == k_idx) begin
                a_bit = a_q[i];
                b_bit = b_q[i];
            end
        end
        // cur_q is zero above T(k), so the shifted copies never overlap or truncate.
        blk_d = ({TMAX{a_bit}} & (cur_q << 1))
              | ({TMAX{b_bit}} & (cur_q << (t_cur + 32'd1)))
              | TMAX'(a_bit & b_bit);
        // Unwritten n bits are zero, so OR-ing the block in is equivalent to a slice write.
        n_d = n_q | (NNL'(blk_d) << blk_off);
    end

`ifdef NL_CARRY_CHECK_EN
    logic chk_err_q;
    logic c_run;
    logic carry_ref;
    logic carry_mis;

    // Reference ripple carry into bit k+1, compared with the parity of the new block.
    always_comb begin
        c_run     = c_in_q;
        carry_ref = c_in_q;
        for (int unsigned i = 0; i < NBIT; i++) begin
            c_run = (a_q[i] & b_q[i]) | ((a_q[i] | b_q[i]) & c_run);
            if (i == k_idx) begin
                carry_ref = c_run;
            end
        end
        carry_mis = ((^blk_d) != carry_ref);
    end

    assign chk_err = chk_err_q;
`endif

    // Control FSM and datapath registers; outputs are registered alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            c_in_q      <= 1'b0;
            cur_q       <= '0;
            k_q         <= '0;
            n_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef NL_CARRY_CHECK_EN
            chk_err_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q        <= a;
                        b_q        <= b;
                        c_in_q     <= c_in;
                        cur_q      <= TMAX'(c_in);
                        k_q        <= '0;
                        n_q        <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
`ifdef NL_CARRY_CHECK_EN
                        chk_err_q  <= 1'b0;
`endif
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    cur_q <= blk_d;
                    n_q   <= n_d;
`ifdef NL_CARRY_CHECK_EN
                    if (carry_mis) begin
                        chk_err_q <= 1'b1;
                    end
`endif
                    if (k_q == KW'(NBIT - 1)) begin
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        k_q <= k_q + KW'(1);
                    end
                end
                DONE: begin
                    // No accept on this edge: in_ready only returns once back in IDLE.
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign n         = n_q;

endmodule

// File: tb/tb_gen_nonlinear_part.sv
// Testbench for gen_nonlinear_part: a hand-computed NBIT=2 vector table, NBIT=7 carry/sum
// property checks over random operands, and directed backpressure, throughput and reset sequences.
module tb_gen_nonlinear_part;

    localparam int unsigned NNL2 = 10;
    localparam int unsigned NNL7 = 501;

    logic clk = 1'b0;
    logic rst;

    logic            iv2, ir2, ov2, or2, ci2, bz2;
    logic [1:0]      a2, b2;
    logic [NNL2-1:0] n2;

    logic            iv7, ir7, ov7, or7, ci7, bz7;
    logic [6:0]      a7, b7;
    logic [NNL7-1:0] n7;

`ifdef NL_CARRY_CHECK_EN
    logic ce2, ce7;
`endif

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    gen_nonlinear_part #(.NBIT(2)) dut2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (iv2),
        .in_ready  (ir2),
        .a         (a2),
        .b         (b2),
        .c_in      (ci2),
        .out_valid (ov2),
        .out_ready (or2),
        .n         (n2),
`ifdef NL_CARRY_CHECK_EN
        .chk_err   (ce2),
`endif
        .busy      (bz2)
    );

    gen_nonlinear_part #(.NBIT(7)) dut7 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (iv7),
        .in_ready  (ir7),
        .a         (a7),
        .b         (b7),
        .c_in      (ci7),
        .out_valid (ov7),
        .out_ready (or7),
        .n         (n7),
`ifdef NL_CARRY_CHECK_EN
        .chk_err   (ce7),
`endif
        .busy      (bz7)
    );

    typedef struct {
        logic [1:0]      a;
        logic [1:0]      b;
        logic            c;
        logic [NNL2-1:0] n;
    } vec2_t;

    vec2_t tbl[9];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One NBIT=2 transaction; operands are scrambled right after acceptance.
    task automatic op2(input logic [1:0] a, input logic [1:0] b, input logic c,
                       output logic [NNL2-1:0] res, output int lat);
        iv2 = 1'b1; a2 = a; b2 = b; ci2 = c;
        tick();
        iv2 = 1'b0; a2 = ~a; b2 = ~b; ci2 = ~c;
        lat = 0;
        while (!ov2 && lat < 20) begin
            tick();
            lat++;
        end
        res = n2;
        or2 = 1'b1;
        tick();
        or2 = 1'b0;
    endtask

    task automatic op7(input logic [6:0] a, input logic [6:0] b, input logic c,
                       output logic [NNL7-1:0] res, output int lat);
        iv7 = 1'b1; a7 = a; b7 = b; ci7 = c;
        tick();
        iv7 = 1'b0; a7 = ~a; b7 = ~b; ci7 = ~c;
        lat = 0;
        while (!ov7 && lat < 40) begin
            tick();
            lat++;
        end
        res = n7;
        or7 = 1'b1;
        tick();
        or7 = 1'b0;
    endtask

    // Parity of each carry block c_1..c_7 of a 501-bit n vector, bit k = block c_k.
    function automatic logic [7:0] blk_xor(input logic [NNL7-1:0] nn);
        logic [7:0] r;
        r = '0;
        for (int k = 1; k <= 7; k++) begin
            int off;
            int t;
            logic x;
            off = (1 << (k + 1)) - 4 - (k - 1);
            t   = (1 << (k + 1)) - 1;
            x   = 1'b0;
            for (int j = 0; j < t; j++) x ^= nn[off + j];
            r[k] = x;
        end
        return r;
    endfunction

    // Ripple-carry reference, bit k = carry into bit k (bit 0 = c_in).
    function automatic logic [7:0] ripple(input logic [6:0] a, input logic [6:0] b, input logic c);
        logic [7:0] r;
        r[0] = c;
        for (int i = 0; i < 7; i++) r[i+1] = (a[i] & b[i]) | (a[i] & r[i]) | (b[i] & r[i]);
        return r;
    endfunction

    task automatic check7(input logic [6:0] a, input logic [6:0] b, input logic c);
        logic [NNL7-1:0] res;
        int              lat;
        logic [7:0]      xv, rc, tot;
        logic [6:0]      s;
        op7(a, b, c, res, lat);
        xv = blk_xor(res);
        rc = ripple(a, b, c);
        chk("lat7", 64'(lat), 64'd7);
        chk("carry7", 64'(xv[7:1]), 64'(rc[7:1]));
        for (int k = 0; k < 7; k++) s[k] = a[k] ^ b[k] ^ ((k == 0) ? c : xv[k]);
        tot = 8'(a) + 8'(b) + 8'(c);
        chk("sum7", 64'(s), 64'(tot[6:0]));
`ifdef NL_CARRY_CHECK_EN
        chk("chk_err_clean", 64'(ce7), 64'd0);
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NNL2-1:0] res2;
        int              lat;
        int              cnt;
        logic            prev;
        logic            found;

        tbl[0] = '{2'd3, 2'd1, 1'b1, 10'h077};
        tbl[1] = '{2'd0, 2'd0, 1'b0, 10'h000};
        tbl[2] = '{2'd3, 2'd3, 1'b1, 10'h3FF};
        tbl[3] = '{2'd1, 2'd2, 1'b0, 10'h000};
        tbl[4] = '{2'd1, 2'd1, 1'b0, 10'h001};
        tbl[5] = '{2'd2, 2'd2, 1'b1, 10'h008};
        tbl[6] = '{2'd2, 2'd1, 1'b1, 10'h044};
        tbl[7] = '{2'd1, 2'd3, 1'b1, 10'h387};
        tbl[8] = '{2'd0, 2'd3, 1'b1, 10'h204};

        rst = 1'b1;
        iv2 = 1'b0; or2 = 1'b0; a2 = '0; b2 = '0; ci2 = 1'b0;
        iv7 = 1'b0; or7 = 1'b0; a7 = '0; b7 = '0; ci7 = 1'b0;
        tick();
        tick();
        chk("rst_in_ready", 64'(ir2), 64'd1);
        chk("rst_out_valid", 64'(ov2), 64'd0);
        chk("rst_busy", 64'(bz2), 64'd0);
        chk("rst_n2", 64'(n2), 64'd0);
        chk("rst_n7_zero", 64'(n7 == '0), 64'd1);
        rst = 1'b0;
        tick();

        // Table of hand-computed NBIT=2 vectors.
        for (int i = 0; i < 9; i++) begin
            op2(tbl[i].a, tbl[i].b, tbl[i].c, res2, lat);
            chk($sformatf("n2_vec%0d", i), 64'(res2), 64'(tbl[i].n));
            chk($sformatf("lat2_vec%0d", i), 64'(lat), 64'd2);
            chk($sformatf("idle_ready_vec%0d", i), 64'(ir2), 64'd1);
        end

        // Cycle-by-cycle view of a=3 b=1 c_in=1 (n was 0x204 from the last vector).
        iv2 = 1'b1; a2 = 2'd3; b2 = 2'd1; ci2 = 1'b1;
        tick();
        iv2 = 1'b0;
        chk("run_busy", 64'(bz2), 64'd1);
        chk("run_in_ready", 64'(ir2), 64'd0);
        chk("run_out_valid", 64'(ov2), 64'd0);
        chk("run_n_cleared", 64'(n2), 64'd0);
        tick();
        chk("run_c1_only", 64'(n2), 64'h007);
        chk("run_out_valid_k1", 64'(ov2), 64'd0);
        tick();
        chk("done_out_valid", 64'(ov2), 64'd1);
        chk("done_busy", 64'(bz2), 64'd0);
        chk("done_n", 64'(n2), 64'h077);

        // Backpressure: hold DONE for 10 cycles while new operands are offered.
        iv2 = 1'b1; a2 = 2'd2; b2 = 2'd1; ci2 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_n_stable", 64'(n2), 64'h077);
            chk("bp_in_ready", 64'(ir2), 64'd0);
            chk("bp_out_valid", 64'(ov2), 64'd1);
        end
        or2 = 1'b1;
        tick();
        or2 = 1'b0;
        chk("bp_release_ov", 64'(ov2), 64'd0);
        chk("bp_release_ready", 64'(ir2), 64'd1);
        chk("bp_no_same_cycle_accept", 64'(bz2), 64'd0);
        tick();
        iv2 = 1'b0;
        chk("bp_accept_next", 64'(bz2), 64'd1);
        tick();
        tick();
        chk("bp_new_ov", 64'(ov2), 64'd1);
        chk("bp_new_n", 64'(n2), 64'h044);
        or2 = 1'b1;
        tick();
        or2 = 1'b0;

        // Throughput with in_valid and out_ready both held high.
        iv2 = 1'b1; or2 = 1'b1; a2 = 2'd3; b2 = 2'd1; ci2 = 1'b1;
        tick();
        chk("tp_first_accept", 64'(bz2), 64'd1);
        prev = bz2; cnt = 0; found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            cnt++;
            if (!prev && bz2) found = 1'b1;
            prev = bz2;
        end
        chk("tp_period", 64'(cnt), 64'd4);
        iv2 = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        or2 = 1'b0;
        chk("tp_back_idle", 64'(ir2), 64'd1);

        // NBIT=7 directed corners and random operands.
        check7(7'h00, 7'h00, 1'b0);
        check7(7'h7F, 7'h7F, 1'b1);
        check7(7'h7F, 7'h00, 1'b1);
        check7(7'h55, 7'h2A, 1'b0);
        for (int i = 0; i < 1000; i++) begin
            check7(7'($urandom), 7'($urandom), 1'($urandom));
        end

        // Reset in the middle of the 4th RUN cycle.
        iv7 = 1'b1; a7 = 7'h7F; b7 = 7'h7F; ci7 = 1'b1;
        tick();
        iv7 = 1'b0;
        tick();
        tick();
        tick();
        chk("mid_partial_nonzero", 64'(n7 != '0), 64'd1);
        chk("mid_busy", 64'(bz7), 64'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_in_ready", 64'(ir7), 64'd1);
        chk("mid_rst_out_valid", 64'(ov7), 64'd0);
        chk("mid_rst_busy", 64'(bz7), 64'd0);
        chk("mid_rst_n_zero", 64'(n7 == '0), 64'd1);
        tick();
        rst = 1'b0;
        tick();
        check7(7'h3C, 7'h19, 1'b1);

`ifdef NL_CARRY_CHECK_EN
        // Corrupt the c_0 block during the first RUN cycle; a[0]^b[0]=1 makes the parity flip.
        iv7 = 1'b1; a7 = 7'h01; b7 = 7'h00; ci7 = 1'b0;
        tick();
        iv7 = 1'b0;
        force dut7.cur_q = 255'd1;
        tick();
        release dut7.cur_q;
        cnt = 0;
        while (!ov7 && cnt < 40) begin
            tick();
            cnt++;
        end
        chk("chk_err_ov", 64'(ov7), 64'd1);
        chk("chk_err_set", 64'(ce7), 64'd1);
        or7 = 1'b1;
        tick();
        or7 = 1'b0;
        check7(7'h01, 7'h00, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
